core_bus_arbiter: RTL and testbench
===================================

# core_bus_arbiter

Parametrised N-channel arbiter that merges the core's request/ready/rvalid memory ports (instruction fetch, data access, future debug/DMA masters) onto one downstream memory port. It extends the dual-port core memory interface to a shared single-port fabric. It tracks outstanding reads in a tag FIFO so that read data returns in order to the issuing channel. It sits between the core top level and the SoC memory/bus adapter.

## Interface
- XLEN, 32, data/address width
- NUM_CH, 2, number of requesting channels (≥1); channel 0 = instruction fetch by convention
- OUTSTANDING, 2, maximum in-flight reads (tag FIFO depth, ≥1)
- clk  in  1  clock; all logic on rising edge
- rst_b  in  1  reset, asynchronous, active-low
- ch_req  in  NUM_CH  per-channel request
- ch_write  in  NUM_CH  per-channel write (1) / read (0)
- ch_wstrb  in  NUM_CH*XLEN/8  packed byte strobes, channel i at [i*XLEN/8 +: XLEN/8]
- ch_addr  in  NUM_CH*XLEN  packed addresses
- ch_wdata  in  NUM_CH*XLEN  packed write data
- ch_ready  out  NUM_CH  request accepted this cycle
- ch_rvalid  out  NUM_CH  read data valid for channel i
- ch_rdata  out  XLEN  read data, broadcast to all channels
- m_req, m_write, m_wstrb, m_addr, m_wdata  out  1/1/XLEN/8/XLEN/XLEN  downstream request
- m_ready  in  1  downstream accepts
- m_rvalid, m_rdata  in  1/XLEN  downstream read return, in order
- outstanding_cnt  out  $clog2(OUTSTANDING+1)  in-flight read count (debug)

## Operation
- Transfer = req && ready in same cycle. Requesters hold req and payload stable until ready.
- Eligible mask: ch_req[i] && (ch_write[i] || !fifo_full). Writes are never throttled; writes produce no rvalid.
- Grant chosen combinationally from eligible mask; m_req = |eligible; m_* payload = granted channel; ch_ready[g] = m_ready only for granted g.
- Grant lock: if m_req && !m_ready, register lock_vld=1, lock_ch=g; while locked, grant is forced to lock_ch regardless of priority; cleared on accepted transfer. Downstream therefore sees a stable payload until accepted.
- Accepted read pushes granted index into tag FIFO. m_rvalid pops head; ch_rvalid[head] = m_rvalid; ch_rdata = m_rdata.
- m_rvalid with empty FIFO: ignored, no ch_rvalid; simulation assertion fires.
- Push and pop in same cycle: count unchanged, both take effect. When full, reads stay blocked that cycle even if pop occurs (no rvalid→ready path).
- Reset (any time): FIFO empty, lock cleared, round-robin pointer = 0; responses arriving for pre-reset reads are dropped by the empty rule.

## Timing
- Request path: zero-cycle combinational (ch_* → m_*, m_ready → ch_ready).
- Response path: zero-cycle combinational (m_rvalid → ch_rvalid).
- Registered state: tag FIFO, count, lock_vld/lock_ch, RR pointer.
- Reset values: outstanding_cnt=0; all ch_ready/ch_rvalid=0 and m_req=0 while inputs idle (outputs purely combinational from reset state).
- Back-to-back acceptance every cycle supported; throughput 1 transfer/cycle.

## Configuration
- CORE_ARB_ROUND_ROBIN_EN defined: round-robin; pointer advances to (granted+1) mod NUM_CH after each accepted transfer; search starts at pointer.
- Not defined: fixed priority, lowest index wins; pointer logic removed. Lock behaviour identical in both.

## Structure
- Shared package core_bus_pkg: bus request struct typedef (write, wstrb, addr, wdata), channel-index width function, channel constants (CH_IFETCH=0, CH_DATA=1).
- One sub-module: core_arb_tag_fifo (depth OUTSTANDING, width $clog2(NUM_CH), push/pop/full/empty/count, async active-low reset).

## Test plan
- NUM_CH=2, ch0 read 0x100 and ch1 read 0x200 same cycle, m_ready=1 → fixed: ch0 accepted first then ch1; RR: alternates across repeated requests.
- ch1 read granted with m_ready=0 for 3 cycles while ch0 asserts → m_addr stays 0x200 until accepted; then ch0 granted.
- OUTSTANDING=2, three reads issued, no m_rvalid → third blocked, outstanding_cnt=2; concurrent write still accepted.
- Reads ch0, ch1, ch0 issued; m_rvalid with data A,B,C → ch_rvalid pulses ch0/ch1/ch0 with ch_rdata A,B,C.
- Push and pop same cycle at count=1 → count stays 1, order preserved.
- rst_b low with 2 reads in flight, then m_rvalid → no ch_rvalid, count=0, assertion logged.

Source files
------------

// File: rtl/core_bus_pkg.sv
// Shared types and constants for the core memory bus and its channel arbiter.
package core_bus_pkg;

    localparam int CH_IFETCH = 0;
    localparam int CH_DATA   = 1;
    localparam int BUS_XLEN  = 32;

    // Request payload as seen on the core's 32-bit memory ports.
    typedef struct packed {
        logic                  write;
        logic [BUS_XLEN/8-1:0] wstrb;
        logic [BUS_XLEN-1:0]   addr;
        logic [BUS_XLEN-1:0]   wdata;
    } bus_req_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/core_arb_tag_fifo.sv
// In-order FIFO of channel indices, one entry per read issued downstream.
module core_arb_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: storage is not reset; an entry is only ever read after it was written, as tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// N-channel arbiter merging core memory ports onto one downstream port with in-order read return.
// Define CORE_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (lowest index).
module core_bus_arbiter
    import core_bus_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_CH      = 2,
    parameter int OUTSTANDING = 2
) (
    input  logic                            clk,
    input  logic                            rst_b,
    input  logic [NUM_CH-1:0]               ch_req,
    input  logic [NUM_CH-1:0]               ch_write,
    input  logic [NUM_CH*XLEN/8-1:0]        ch_wstrb,
    input  logic [NUM_CH*XLEN-1:0]          ch_addr,
    input  logic [NUM_CH*XLEN-1:0]          ch_wdata,
    output logic [NUM_CH-1:0]               ch_ready,
    output logic [NUM_CH-1:0]               ch_rvalid,
    output logic [XLEN-1:0]                 ch_rdata,
    output logic                            m_req,
    output logic                            m_write,
    output logic [XLEN/8-1:0]               m_wstrb,
    output logic [XLEN-1:0]                 m_addr,
    output logic [XLEN-1:0]                 m_wdata,
    input  logic                            m_ready,
    input  logic                            m_rvalid,
    input  logic [XLEN-1:0]                 m_rdata,
    output logic [$clog2(OUTSTANDING+1)-1:0] outstanding_cnt
);

    localparam int IDX_W = ch_idx_w(NUM_CH);
    localparam int SW    = XLEN / 8;

    typedef struct packed {
        logic            write;
        logic [SW-1:0]   wstrb;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } req_t;

    logic [NUM_CH-1:0] eligible;
    logic [IDX_W-1:0]  prio_grant, grant, head;
    logic [IDX_W-1:0]  lock_ch_q, lock_ch_d;
    logic              lock_vld_q, lock_vld_d;
    logic              accept, push, pop, fifo_full, fifo_empty;
    req_t              sel;

    // Reads are held back when the tag FIFO is full; writes never wait on it.
    assign eligible = ch_req & (ch_write | {NUM_CH{!fifo_full}});
    assign m_req    = |eligible;
    assign accept   = m_req && m_ready;
    assign grant    = lock_vld_q ? lock_ch_q : prio_grant;

`ifdef CORE_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d, rr_off;
    logic [NUM_CH-1:0] rr_rot;
    logic [IDX_W:0]    rr_sum;

    always_comb begin
        rr_rot = NUM_CH'({eligible, eligible} >> rr_ptr_q);
        rr_off = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rr_rot[k]) rr_off = IDX_W'(k);
        end
        rr_sum = {1'b0, rr_ptr_q} + {1'b0, rr_off};
        if (rr_sum >= (IDX_W+1)'(NUM_CH)) rr_sum = rr_sum - (IDX_W+1)'(NUM_CH);
        prio_grant = rr_sum[IDX_W-1:0];
        rr_ptr_d   = rr_ptr_q;
        if (accept) rr_ptr_d = (grant == IDX_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`else
    always_comb begin
        prio_grant = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eligible[i]) prio_grant = IDX_W'(i);
        end
    end
`endif

    always_comb begin
        sel       = '0;
        ch_ready  = '0;
        ch_rvalid = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == IDX_W'(i)) begin
                sel         = {ch_write[i], ch_wstrb[i*SW +: SW], ch_addr[i*XLEN +: XLEN], ch_wdata[i*XLEN +: XLEN]};
                ch_ready[i] = accept;
            end
            ch_rvalid[i] = pop && (head == IDX_W'(i));
        end
    end

    assign m_write  = sel.write;
    assign m_wstrb  = sel.wstrb;
    assign m_addr   = sel.addr;
    assign m_wdata  = sel.wdata;
    assign ch_rdata = m_rdata;
    assign push     = accept && !sel.write;
    assign pop      = m_rvalid && !fifo_empty;

    // A stalled grant is pinned so the downstream payload cannot change before it is taken.
    always_comb begin
        lock_vld_d = m_req && !m_ready;
        lock_ch_d  = lock_vld_d ? grant : lock_ch_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lock_vld_q <= 1'b0;
            lock_ch_q  <= '0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_ch_q  <= lock_ch_d;
        end
    end

    core_arb_tag_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (push),
        .push_data (grant),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outstanding_cnt)
    );

`ifndef SYNTHESIS
    // Responses with nothing in flight (e.g. reads issued before a reset) are dropped.
    orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_b) !(m_rvalid && fifo_empty))
        else $warning("core_bus_arbiter: m_rvalid with no outstanding read, dropped");
`endif

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Self-checking bench for core_bus_arbiter: queue-based reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_core_bus_arbiter;

    localparam int XLEN        = 32;
    localparam int NUM_CH      = 2;
    localparam int OUTSTANDING = 2;
    localparam int SW          = XLEN / 8;
    localparam int CNT_W       = $clog2(OUTSTANDING + 1);

    typedef struct {
        logic            write;
        logic [SW-1:0]   wstrb;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } item_t;

    logic                     clk = 1'b0;
    logic                     rst_b;
    logic [NUM_CH-1:0]        ch_req, ch_write, ch_ready, ch_rvalid;
    logic [NUM_CH*SW-1:0]     ch_wstrb;
    logic [NUM_CH*XLEN-1:0]   ch_addr, ch_wdata;
    logic [XLEN-1:0]          ch_rdata, m_addr, m_wdata, m_rdata;
    logic                     m_req, m_write, m_ready, m_rvalid;
    logic [SW-1:0]            m_wstrb;
    logic [CNT_W-1:0]         outstanding_cnt;

    int checks = 0;
    int errors = 0;

    item_t             chq [NUM_CH][$];
    logic [NUM_CH-1:0] acc_seen = '0;
    int                acc_log[$];
    int                mq[$];
    int                m_lock = -1;
    int                m_rr   = 0;

    core_bus_arbiter #(.XLEN(XLEN), .NUM_CH(NUM_CH), .OUTSTANDING(OUTSTANDING)) dut (
        .clk(clk), .rst_b(rst_b),
        .ch_req(ch_req), .ch_write(ch_write), .ch_wstrb(ch_wstrb), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_ready(ch_ready), .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata),
        .m_req(m_req), .m_write(m_write), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .outstanding_cnt(outstanding_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic item_t mk(input logic wr, input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data);
        item_t it;
        it.write = wr;
        it.wstrb = wr ? '1 : '0;
        it.addr  = addr;
        it.wdata = data;
        return it;
    endfunction

    // Accepted channels since 'from', one nibble per transfer (channel+1), oldest first.
    function automatic logic [31:0] log_code(input int from);
        logic [31:0] code = '0;
        for (int k = from; k < acc_log.size(); k++) code = (code << 4) | 32'(acc_log[k] + 1);
        return code;
    endfunction

    // Requester agent: holds each queued request until it is seen accepted.
    initial begin
        ch_req = '0; ch_write = '0; ch_wstrb = '0; ch_addr = '0; ch_wdata = '0;
        forever begin
            @(posedge clk); #2;
            for (int i = 0; i < NUM_CH; i++) begin
                if (acc_seen[i] && chq[i].size() > 0) void'(chq[i].pop_front());
                ch_req[i] = (chq[i].size() > 0);
                if (chq[i].size() > 0) begin
                    ch_write[i]              = chq[i][0].write;
                    ch_wstrb[i*SW +: SW]     = chq[i][0].wstrb;
                    ch_addr[i*XLEN +: XLEN]  = chq[i][0].addr;
                    ch_wdata[i*XLEN +: XLEN] = chq[i][0].wdata;
                end else begin
                    ch_write[i]              = 1'b0;
                    ch_wstrb[i*SW +: SW]     = '0;
                    ch_addr[i*XLEN +: XLEN]  = '0;
                    ch_wdata[i*XLEN +: XLEN] = '0;
                end
            end
        end
    end

    // Reference model and per-cycle comparison.
    always @(negedge clk) begin
        logic [NUM_CH-1:0] elig, e_ready, e_rvalid;
        logic [127:0]      e_pay;
        logic              e_mreq, sel_w;
        int                g;

        acc_seen = ch_req & ch_ready;
        for (int i = 0; i < NUM_CH; i++) if (acc_seen[i]) acc_log.push_back(i);

        if (!rst_b) begin
            mq.delete();
            m_lock = -1;
            m_rr   = 0;
        end

        for (int i = 0; i < NUM_CH; i++) elig[i] = ch_req[i] && (ch_write[i] || mq.size() < OUTSTANDING);
        g = -1;
        if (m_lock >= 0) g = m_lock;
        else for (int k = 0; k < NUM_CH; k++) if (g < 0 && elig[(m_rr + k) % NUM_CH]) g = (m_rr + k) % NUM_CH;

        e_mreq = |elig;
        e_pay  = '0;
        sel_w  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i == g) begin
                e_pay = {ch_write[i], ch_wstrb[i*SW +: SW], ch_addr[i*XLEN +: XLEN], ch_wdata[i*XLEN +: XLEN]};
                sel_w = ch_write[i];
            end
        end
        e_ready  = (e_mreq && m_ready) ? (NUM_CH'(1) << g) : '0;
        e_rvalid = (m_rvalid && mq.size() > 0) ? (NUM_CH'(1) << mq[0]) : '0;

        check("m_req", m_req, e_mreq);
        check("ch_ready", ch_ready, e_ready);
        check("ch_rvalid", ch_rvalid, e_rvalid);
        check("outstanding_cnt", outstanding_cnt, mq.size());
        if (e_mreq) check("m_payload", {m_write, m_wstrb, m_addr, m_wdata}, e_pay);
        if (|e_rvalid) check("ch_rdata", ch_rdata, m_rdata);

        if (rst_b) begin
            if (m_rvalid && mq.size() > 0) void'(mq.pop_front());
            if (e_mreq && m_ready) begin
                if (!sel_w) mq.push_back(g);
                m_lock = -1;
`ifdef CORE_ARB_ROUND_ROBIN_EN
                m_rr = (g + 1) % NUM_CH;
`endif
            end else if (e_mreq) begin
                m_lock = g;
            end
        end
    end

    task automatic to_pos();
        @(posedge clk); #1;
    endtask

    task automatic to_neg();
        @(negedge clk); #1;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((chq[0].size() + chq[1].size()) != 0 && n < max) begin
            to_pos();
            n++;
        end
        check("idle_wait", (chq[0].size() + chq[1].size()) == 0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark;
        rst_b = 1'b0; m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        repeat (2) to_pos();
        rst_b = 1'b1;
        to_neg();
        check("rst_cnt", outstanding_cnt, 0);
        check("rst_m_req", m_req, 0);
        check("rst_ch_ready", ch_ready, 0);
        check("rst_ch_rvalid", ch_rvalid, 0);

        // Simultaneous reads from both channels.
        to_pos();
        m_ready = 1'b1;
        mark = acc_log.size();
        chq[0].push_back(mk(1'b0, 32'h100, '0));
        chq[1].push_back(mk(1'b0, 32'h200, '0));
        wait_idle(20);
        to_neg();
        check("t1_order", log_code(mark), 32'h12);
        check("t1_cnt", outstanding_cnt, 2);

        // FIFO full: read blocked, write still accepted.
        to_pos();
        mark = acc_log.size();
        chq[0].push_back(mk(1'b0, 32'h104, '0));
        chq[1].push_back(mk(1'b1, 32'h300, 32'hCAFE_0001));
        repeat (3) to_pos();
        to_neg();
        check("t3_order", log_code(mark), 32'h2);
        check("t3_cnt", outstanding_cnt, 2);
        check("t3_blocked", ch_ready, 2'b00);

        // In-order return; blocked read accepted together with a pop.
        to_pos();
        m_rvalid = 1'b1; m_rdata = 32'hAAAA_0001;
        to_neg();
        check("rv_a_valid", ch_rvalid, 2'b01);
        check("rv_a_data", ch_rdata, 32'hAAAA_0001);
        check("rv_a_noready", ch_ready, 2'b00);
        to_pos();
        m_rdata = 32'hBBBB_0002;
        to_neg();
        check("rv_b_valid", ch_rvalid, 2'b10);
        check("rv_b_ready", ch_ready, 2'b01);
        check("rv_b_cnt", outstanding_cnt, 1);
        to_pos();
        m_rdata = 32'hCCCC_0003;
        to_neg();
        check("pushpop_cnt", outstanding_cnt, 1);
        check("rv_c_valid", ch_rvalid, 2'b01);
        check("rv_c_data", ch_rdata, 32'hCCCC_0003);
        to_pos();
        m_rvalid = 1'b0;
        to_neg();
        check("drain_cnt", outstanding_cnt, 0);

        // Grant lock under downstream stall.
        to_pos();
        m_ready = 1'b0;
        mark = acc_log.size();
        chq[1].push_back(mk(1'b0, 32'h200, '0));
        to_neg();
        check("lock_addr0", m_addr, 32'h200);
        to_pos();
        chq[0].push_back(mk(1'b0, 32'h108, '0));
        to_neg();
        check("lock_addr1", m_addr, 32'h200);
        check("lock_noready", ch_ready, 2'b00);
        to_pos();
        to_neg();
        check("lock_addr2", m_addr, 32'h200);
        to_pos();
        m_ready = 1'b1;
        to_neg();
        check("lock_accept", ch_ready, 2'b10);
        check("lock_addr3", m_addr, 32'h200);
        to_pos();
        to_neg();
        check("after_lock_ready", ch_ready, 2'b01);
        check("after_lock_addr", m_addr, 32'h108);
        to_pos();
        m_rvalid = 1'b1; m_rdata = 32'hDDDD_0004;
        to_neg();
        check("lock_order", log_code(mark), 32'h21);
        check("rv_d_valid", ch_rvalid, 2'b10);
        to_pos();
        m_rdata = 32'hEEEE_0005;
        to_neg();
        check("rv_e_valid", ch_rvalid, 2'b01);
        to_pos();
        m_rvalid = 1'b0;

        // Competing back-to-back writes: arbitration policy.
        mark = acc_log.size();
        chq[0].push_back(mk(1'b1, 32'h400, 32'h0000_0400));
        chq[0].push_back(mk(1'b1, 32'h404, 32'h0000_0404));
        chq[1].push_back(mk(1'b1, 32'h500, 32'h0000_0500));
        chq[1].push_back(mk(1'b1, 32'h504, 32'h0000_0504));
        wait_idle(20);
        to_neg();
`ifdef CORE_ARB_ROUND_ROBIN_EN
        check("prio_order", log_code(mark), 32'h2121);
`else
        check("prio_order", log_code(mark), 32'h1122);
`endif
        check("writes_no_cnt", outstanding_cnt, 0);

        // Reset with reads in flight; late responses are dropped.
        to_pos();
        chq[0].push_back(mk(1'b0, 32'h600, '0));
        chq[1].push_back(mk(1'b0, 32'h700, '0));
        wait_idle(20);
        to_neg();
        check("pre_rst_cnt", outstanding_cnt, 2);
        to_pos();
        rst_b = 1'b0;
        to_neg();
        check("in_rst_cnt", outstanding_cnt, 0);
        to_pos();
        rst_b = 1'b1;
        to_pos();
        m_rvalid = 1'b1; m_rdata = 32'hFFFF_0006;
        to_neg();
        check("orphan_no_rvalid", ch_rvalid, 2'b00);
        check("orphan_cnt", outstanding_cnt, 0);
        to_pos();
        m_rvalid = 1'b0;
        repeat (2) to_pos();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
